// File: rtl/piso_serializer_pkg.sv
// Shared word width, transmitter state encoding and counter sizing helper.
package piso_serializer_pkg;

  localparam int unsigned DW = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } tx_state_e;

  // Bit-counter width; a 1-bit word still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned dw);
    return (dw > 1) ? $clog2(dw) : 1;
  endfunction

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Counts transmitted bits of a word; flags the last bit position (DW-1).
module piso_serializer_bit_counter
  import piso_serializer_pkg::*;
#(
  parameter int unsigned DW = piso_serializer_pkg::DW
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  localparam int unsigned CW = cnt_width(DW);

  logic [CW-1:0] bit_cnt;

  // Counter register: clear has priority over enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
    end else if (clr) begin
      bit_cnt <= '0;
    end else if (en) begin
      bit_cnt <= bit_cnt + CW'(1);
    end
  end

  assign tc_c = (bit_cnt == CW'(DW - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: captures a word on handshake and shifts it out.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int unsigned DW        = piso_serializer_pkg::DW,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          ser_out,
  output logic          ser_valid,
  output logic          frame_done,
  output logic          busy
);

  tx_state_e     state_q, state_d;
  logic [DW-1:0] shreg_q, shreg_d;
  logic          cnt_clr;
  logic          cnt_en;
  logic          cnt_tc_c;

  piso_serializer_bit_counter #(
    .DW (DW)
  ) u_bit_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .tc_c (cnt_tc_c)
  );

  // State and shift register; reset drops any word offered in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end

  // Next state, shift data and state-decoded outputs (no input-to-output paths).
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    in_ready   = 1'b0;
    ser_out    = 1'b0;
    ser_valid  = 1'b0;
    frame_done = 1'b0;
    busy       = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shreg_d = in_data;
          cnt_clr = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        ser_valid = 1'b1;
        busy      = 1'b1;
        ser_out   = LSB_FIRST ? shreg_q[0] : shreg_q[DW-1];
        shreg_d   = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
        if (cnt_tc_c) begin
          cnt_clr = 1'b1;
          state_d = DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE: begin
        frame_done = 1'b1;
        busy       = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench: three serializer variants driven in parallel and checked against a frame-position model.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic [2:0] rdy, so, sv, fd, bz;

  always #5 clk = ~clk;

  piso_serializer #(.DW(8), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[0]), .ser_out(so[0]), .ser_valid(sv[0]), .frame_done(fd[0]), .busy(bz[0]));

  piso_serializer #(.DW(8), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[1]), .ser_out(so[1]), .ser_valid(sv[1]), .frame_done(fd[1]), .busy(bz[1]));

  piso_serializer #(.DW(1), .LSB_FIRST(1'b1)) u_one (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data[0:0]),
    .in_ready(rdy[2]), .ser_out(so[2]), .ser_valid(sv[2]), .frame_done(fd[2]), .busy(bz[2]));

  // Model: pos = -1 idle, 0..dw-1 = index of bit on the wire, dw = end-of-frame cycle.
  int         dw  [3] = '{8, 8, 1};
  bit         lsb [3] = '{1'b1, 1'b0, 1'b1};
  int         pos [3] = '{-1, -1, -1};
  logic [7:0] word[3];
  logic [7:0] col [3];
  int         ncol[3] = '{0, 0, 0};
  int         start_last[3] = '{0, 0, 0};
  int         start_prev[3] = '{0, 0, 0};
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: advance the model with the inputs in force, then compare all outputs.
  task automatic cycle();
    int   idx;
    logic e_so;
    for (int m = 0; m < 3; m++) begin
      if (rst) pos[m] = -1;
      else if (pos[m] < 0) begin
        if (in_valid) begin
          word[m] = in_data;
          pos[m]  = 0;
        end
      end else if (pos[m] < dw[m]) pos[m]++;
      else pos[m] = -1;
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int m = 0; m < 3; m++) begin
      e_so = 1'b0;
      if (pos[m] >= 0 && pos[m] < dw[m]) begin
        idx  = lsb[m] ? pos[m] : dw[m] - 1 - pos[m];
        e_so = word[m][idx];
      end
      chk($sformatf("in_ready[%0d]", m),   32'(rdy[m]), 32'(pos[m] < 0));
      chk($sformatf("busy[%0d]", m),       32'(bz[m]),  32'(pos[m] >= 0));
      chk($sformatf("ser_valid[%0d]", m),  32'(sv[m]),  32'(pos[m] >= 0 && pos[m] < dw[m]));
      chk($sformatf("frame_done[%0d]", m), 32'(fd[m]),  32'(pos[m] == dw[m]));
      chk($sformatf("ser_out[%0d]", m),    32'(so[m]),  32'(e_so));
      // Reassemble each frame from the wire and compare against the captured word.
      if (rst) ncol[m] = 0;
      if (sv[m] === 1'b1) begin
        if (ncol[m] == 0) begin
          start_prev[m] = start_last[m];
          start_last[m] = cyc;
        end
        ncol[m]++;
        if (dw[m] == 1)  col[m] = {7'b0, so[m]};
        else if (lsb[m]) col[m] = {so[m], col[m][7:1]};
        else             col[m] = {col[m][6:0], so[m]};
      end
      if (fd[m] === 1'b1) begin
        chk($sformatf("frame_len[%0d]", m), 32'(ncol[m]), 32'(dw[m]));
        chk($sformatf("frame_word[%0d]", m), 32'(col[m]),
            (dw[m] == 1) ? 32'(word[m][0]) : 32'(word[m]));
        ncol[m] = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Offer one word once the 8-bit LSB-first unit is ready; data is scrambled afterwards.
  task automatic send(input logic [7:0] w);
    int budget;
    budget = 0;
    in_valid = 1'b0;
    while (rdy[0] !== 1'b1 && budget < 20) begin
      cycle();
      budget++;
    end
    if (rdy[0] !== 1'b1) chk("ready_timeout", 32'(rdy[0]), 32'd1);
    in_valid = 1'b1;
    in_data  = w;
    cycle();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    cycle();
    cycle();
    rst = 1'b0;
    idle(3);

    // LSB-first A5, then let the frame complete.
    send(8'hA5);
    idle(12);

    // 81 then 3C back-to-back with in_valid held high.
    in_valid = 1'b1;
    in_data  = 8'h81;
    cycle();
    in_data  = 8'h3C;
    for (int i = 0; i < 11; i++) cycle();
    in_valid = 1'b0;
    chk("b2b_gap", 32'(start_last[0] - start_prev[0]), 32'd10);
    chk("b2b_gap_msb", 32'(start_last[1] - start_prev[1]), 32'd10);
    idle(12);

    // Competing word offered while FF is shifting must wait for in_ready.
    send(8'hFF);
    in_valid = 1'b1;
    in_data  = 8'h00;
    for (int i = 0; i < 12; i++) cycle();
    in_valid = 1'b0;
    idle(12);

    // Reset in the cycle bit 4 of C3 is on the wire, then a clean 5A.
    send(8'hC3);
    idle(4);
    chk("abort_pre_busy", 32'(bz[0]), 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("abort_idle_ready", 32'(rdy[0]), 32'd1);
    idle(3);
    send(8'h5A);
    idle(12);

    // Single-bit frames for the DW=1 unit.
    send(8'h01);
    idle(11);
    send(8'h00);
    idle(11);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 59) == 0);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      cycle();
    end
    rst = 1'b0;
    idle(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter: accepts one DW-bit word over a valid/ready handshake and shifts it out one bit per clock.
- Serves as the sending end of the team's parallel word datapath, which ends in the parallel-in/parallel-out holding register.
- The word is captured on acceptance, so the upstream producer may change in_data immediately after the handshake.
- Frame framing is explicit: ser_valid marks data bits, frame_done marks the end of each word.

Parameters:
- DW, default Global::DW (8 in Global), word width in bits; legal range DW >= 1.
- LSB_FIRST, default 1; 1 = bit 0 transmitted first, 0 = bit DW-1 transmitted first.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  upstream word available.
- in_data  in  DW  parallel word; sampled only on handshake.
- in_ready  out  1  serializer can accept a word (high only in IDLE).
- ser_out  out  1  current serial bit.
- ser_valid  out  1  ser_out carries a data bit this cycle.
- frame_done  out  1  one-cycle pulse after the last bit of a word.
- busy  out  1  high in SHIFT or DONE.

Behaviour:
- Interface (already decided): one clock, clk; reset port rst is synchronous and active-high.
- State register: tx_state_e {IDLE, SHIFT, DONE}, register bit_cnt of width max(1,$clog2(DW)), register shreg of width DW.
- Reset: rst=1 at a clk edge forces state=IDLE, bit_cnt=0, shreg=0. From the following cycle: in_ready=1, ser_out=0, ser_valid=0, frame_done=0, busy=0.
- Reset priority: rst overrides any handshake in the same cycle, so a word offered then is dropped. Reset mid-frame aborts the frame with no frame_done.
- Handshake: a transfer occurs at an edge where in_valid && in_ready. in_valid while in_ready=0 is ignored; no buffering, no error flag. in_data changes outside the handshake have no effect.
- IDLE:
  - in_ready=1, busy=0, ser_valid=0, ser_out=0.
  - On transfer: shreg<=in_data, bit_cnt<=0, next state SHIFT.
- SHIFT:
  - ser_valid=1, busy=1, in_ready=0.
  - ser_out = shreg[0] if LSB_FIRST, else shreg[DW-1].
  - Each edge: shreg shifts toward the output end with zero fill, and bit_cnt increments.
  - When bit_cnt==DW-1 at an edge: next state DONE, bit_cnt<=0.
- DONE: frame_done=1, busy=1, ser_valid=0, ser_out=0, in_ready=0; next state IDLE unconditionally.
- Timing, for a transfer at edge k:
  - Bit 0 (first-sent bit) is visible in the cycle after edge k.
  - Bits occupy DW consecutive cycles.
  - frame_done is high in cycle k+DW+1.
  - in_ready is high again in cycle k+DW+2.
  - Minimum word period is DW+2 cycles.
- DW=1: SHIFT lasts exactly one cycle and bit_cnt stays 0.
- Outputs are decoded from state/shreg only, with no input-to-output combinational paths. Specifically, in_ready does not depend on in_valid.

Decomposition:
- Global package: DW (existing); add typedef enum logic [1:0] tx_state_e {IDLE, SHIFT, DONE}; add localparam function for counter width CW = (DW>1)?$clog2(DW):1.
- One natural sub-module, bit_counter: synchronous clear, enable, terminal-count output at DW-1, CW-bit.
- FSM and shift register remain in piso_serializer.

Test Plan (DW=8):
- Reset: hold rst=1 for 2 cycles with in_valid=1, in_data=8'hFF -> in_ready=1, busy=0, ser_valid=0, frame_done=0, and no frame starts.
- LSB_FIRST=1, send 8'hA5 -> ser_out sequence 1,0,1,0,0,1,0,1 with ser_valid=1 for exactly 8 cycles; frame_done pulses once in the 9th cycle after the handshake; in_ready returns on the 10th.
- LSB_FIRST=0, send 8'h81 -> ser_out 1,0,0,0,0,0,0,1; then send 8'h3C back-to-back with in_valid held high -> the second frame starts exactly 10 cycles after the first handshake.
- Drive in_valid=1, in_data=8'h00 during SHIFT of word 8'hFF -> all 8 output bits=1, the new word is not accepted until in_ready=1.
- Assert rst for one cycle at bit 4 of 8'hC3 -> the next cycle shows IDLE outputs, no frame_done, and a subsequent 8'h5A transmits correctly.
- DW=1, send 1'b1 then 1'b0 -> each frame is 1 ser_valid cycle then 1 frame_done cycle, with ser_out 1 then 0.
